alu_fu_sched: RTL and testbench
===============================

# alu_fu_sched

Issue scheduler that shares the single multi-cycle ALU functional unit among `N_REQ` requesters (reservation-station / issue slots) of the scoreboard pipeline. It grants round-robin and captures the operands. It drives the FU's one-cycle `EN` handshake, collects `res`/`zero`/`overflow` on `finish`, and holds the tagged result on a write-back port until the common data bus accepts it.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `TAG_W`, 3, destination tag width
- `TIMEOUT`, 8, WAIT cycles without `fu_finish` before reissue
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  N_REQ  per-requester operation pending
- `req_ctrl`  in  4*N_REQ  ALU control code, slot i at [4i+3:4i]
- `req_a`, `req_b`  in  32*N_REQ  operands, slot i at [32i+31:32i]
- `req_tag`  in  TAG_W*N_REQ  destination tag per slot
- `req_ready`  out  N_REQ  one-hot grant pulse; the slot's operands are consumed this cycle
- `fu_en`  out  1  to FU `EN`
- `fu_ctrl`  out  4  to FU `ALUControl`
- `fu_a`, `fu_b`  out  32  to FU `ALUA`/`ALUB`
- `fu_res`  in  32  from FU `res`
- `fu_zero`, `fu_overflow`, `fu_finish`  in  1  from FU
- `wb_valid`  out  1  result available
- `wb_ready`  in  1  CDB accepts result
- `wb_tag`  out  TAG_W  tag of result
- `wb_src`  out  3  index of the originating slot
- `wb_res`  out  32  result
- `wb_zero`, `wb_overflow`  out  1  flags captured with result
- `err_timeout`  out  1  sticky; set when a reissue has occurred
- `op_count`  out  32  completed write-backs; wraps mod 2^32

## Operation
- FSM states are IDLE, ISSUE, WAIT and WB.
- IDLE: if any `req_valid` is set, pick the first set bit searching from `last+1` modulo N_REQ. `last` is the previously granted index and resets to N_REQ-1, so slot 0 wins first.
  - Pulse `req_ready[i]` for one cycle.
  - Register ctrl/a/b/tag/index.
  - Set `last` to i and go to ISSUE. No grant is issued in any other state.
- ISSUE: `fu_en`=1 for exactly one cycle, with `fu_ctrl`/`fu_a`/`fu_b` driven from the registered operands. Clear the watchdog and go to WAIT.
- WAIT: `fu_en`=0.
  - If `fu_finish`: capture `fu_res`, `fu_zero` and `fu_overflow` into the wb registers and go to WB.
  - Otherwise increment the watchdog. When it reaches TIMEOUT, set `err_timeout` and return to ISSUE with the same operands.
- WB: `wb_valid`=1 and all wb outputs are stable. On `wb_valid & wb_ready`: increment `op_count` and go to IDLE.
- `fu_en` must never be high on two consecutive cycles. The FU toggles its state, and back-to-back EN would drop an operation.
- `fu_finish` is ignored outside WAIT.
- `fu_a`, `fu_b` and `fu_ctrl` hold their last values outside ISSUE. The FU latches them only on EN.
- A requester dropping `req_valid` before it is granted is legal. Only the `req_valid` value in the grant cycle matters.

## Timing
- Reset values of outputs:
  - `req_ready`=0, `fu_en`=0, `fu_ctrl`=0, `fu_a`=0, `fu_b`=0.
  - `wb_valid`=0, `wb_tag`=0, `wb_src`=0, `wb_res`=0, `wb_zero`=0, `wb_overflow`=0.
  - `err_timeout`=0, `op_count`=0.
- Reset values of internal state: FSM=IDLE, `last`=N_REQ-1.
- Latency, with a grant in cycle T:
  - `fu_en`=1 in T+1.
  - FU `finish` and capture in T+2.
  - `wb_valid`=1 from T+3.
- Best-case throughput is one operation per 4 cycles with `wb_ready` held high. The next grant can come in the cycle after the WB handshake.
- Reset is asynchronous and may be asserted mid-operation. All state clears immediately and any in-flight result is discarded; no write-back occurs.
- The FU itself has no reset, so its busy state can be stale after reset. That state lasts at most one cycle. The mandatory IDLE grant cycle before ISSUE guarantees the FU is idle when EN arrives.
- `wb_ready` may stay low indefinitely. The scheduler holds WB with outputs frozen, and all `req_ready` stay 0.
- Watchdog: a reissue occurs after TIMEOUT+1 cycles in WAIT. The count is 5 bits wide and saturates.

## Test plan
- Single request: slot 2 requests ADD with a=5, b=7, tag=3, and `wb_ready`=1.
  - Required: `req_ready`=0100 at T and `fu_en` at T+1.
  - Required: `wb_valid` at T+3 with `wb_res`=12, `wb_tag`=3, `wb_src`=2, zero=0.
  - Required: `op_count`=1.
- Round-robin: all four slots valid continuously.
  - Required: grant order 0,1,2,3,0 at 4-cycle spacing.
  - Required: `fu_en` is never high on two consecutive cycles.
- Backpressure: SUB with a=3, b=3, and `wb_ready` low for 10 cycles.
  - Required: `wb_valid` held, `wb_res`=0, `wb_zero`=1 and no grants for those cycles.
  - Required: after `wb_ready` rises, `op_count` increments once.
- Overflow flag: ADD with a=0x7FFFFFFF, b=1.
  - Required: `wb_res`=0x80000000, `wb_overflow`=1.
- Timeout: the FU model suppresses `finish` for the first issue.
  - Required: after TIMEOUT+1 WAIT cycles, `err_timeout`=1 and a second `fu_en` pulse occurs.
  - Required: the result is written back once, and `op_count`=1.
- Reset mid-op: assert `rst_n`=0 during WAIT.
  - Required: all outputs reach their reset values immediately, with no `wb_valid`.
  - Required: after release, a slot 0 request completes normally with 3-cycle latency to `wb_valid`.

Source files
------------

// File: rtl/alu_fu_sched_if.sv
// Bundle between the issue scheduler and its environment: the requester
// slots, the shared ALU functional unit and the common-data-bus write-back.
//
// Handshake rules:
//   - req_valid/req_ready: a slot's operands are taken in the one cycle in
//     which req_ready[i] is high. req_ready is a one-hot pulse. A slot may drop
//     req_valid at any time before it is granted.
//   - fu_en: a single-cycle strobe. The FU latches ctrl/a/b on it and later
//     answers with a one-cycle fu_finish together with res/zero/overflow.
//   - wb_valid/wb_ready: a result transfers on a cycle with both high. While
//     wb_valid is high and wb_ready is low, every wb_* signal holds steady.
interface alu_fu_sched_if #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 3
);
    logic [N_REQ-1:0]       req_valid;
    logic [4*N_REQ-1:0]     req_ctrl;
    logic [32*N_REQ-1:0]    req_a;
    logic [32*N_REQ-1:0]    req_b;
    logic [TAG_W*N_REQ-1:0] req_tag;
    logic [N_REQ-1:0]       req_ready;

    logic                   fu_en;
    logic [3:0]             fu_ctrl;
    logic [31:0]            fu_a;
    logic [31:0]            fu_b;
    logic [31:0]            fu_res;
    logic                   fu_zero;
    logic                   fu_overflow;
    logic                   fu_finish;

    logic                   wb_valid;
    logic                   wb_ready;
    logic [TAG_W-1:0]       wb_tag;
    logic [2:0]             wb_src;
    logic [31:0]            wb_res;
    logic                   wb_zero;
    logic                   wb_overflow;

    // Scheduler side
    modport master (
        input  req_valid, req_ctrl, req_a, req_b, req_tag,
        output req_ready,
        output fu_en, fu_ctrl, fu_a, fu_b,
        input  fu_res, fu_zero, fu_overflow, fu_finish,
        output wb_valid, wb_tag, wb_src, wb_res, wb_zero, wb_overflow,
        input  wb_ready
    );

    // Requesters, functional unit and write-back consumer side
    modport slave (
        output req_valid, req_ctrl, req_a, req_b, req_tag,
        input  req_ready,
        input  fu_en, fu_ctrl, fu_a, fu_b,
        output fu_res, fu_zero, fu_overflow, fu_finish,
        input  wb_valid, wb_tag, wb_src, wb_res, wb_zero, wb_overflow,
        output wb_ready
    );
endinterface

// File: rtl/alu_fu_sched.sv
// Issue scheduler for the single shared multi-cycle ALU functional unit.
// It grants requester slots round-robin and captures the granted operands.
// It strobes the FU once per operation and collects the result on finish.
// It then holds the tagged result on the write-back port until it is accepted.
// A watchdog reissues the operation if the FU never answers.
module alu_fu_sched #(
    parameter int N_REQ   = 4,
    parameter int TAG_W   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_fu_sched_if.master      bus,
    output logic                err_timeout,
    output logic [31:0]         op_count,
    output logic [1:0]          state_dbg
);

    localparam int         IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [4:0] WDOG_LIMIT = 5'(TIMEOUT);
    localparam logic [4:0] WDOG_MAX   = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t             state_q, state_d;

    // Arbitration pointer and captured operation
    logic [IDX_W-1:0]   last_q;
    logic [3:0]         op_ctrl_q;
    logic [31:0]        op_a_q;
    logic [31:0]        op_b_q;
    logic [TAG_W-1:0]   op_tag_q;
    logic [IDX_W-1:0]   op_src_q;

    // Watchdog counting WAIT cycles without a finish
    logic [4:0]         wdog_q;

    // Write-back holding registers
    logic [TAG_W-1:0]   wb_tag_q;
    logic [2:0]         wb_src_q;
    logic [31:0]        wb_res_q;
    logic               wb_zero_q;
    logic               wb_ovf_q;

    logic               err_q;
    logic [31:0]        cnt_q;

    // Combinational arbitration / control strobes
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic [3:0]         sel_ctrl;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [TAG_W-1:0]   sel_tag;
    logic               grant_fire;
    logic               capture;
    logic               reissue;
    logic               wb_fire;

    // Round-robin search: first valid slot starting just after the last grant
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % N_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Operand mux for the slot selected by the arbiter
    always_comb begin
        sel_ctrl = '0;
        sel_a    = '0;
        sel_b    = '0;
        sel_tag  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_ctrl = bus.req_ctrl[i*4 +: 4];
                sel_a    = bus.req_a[i*32 +: 32];
                sel_b    = bus.req_b[i*32 +: 32];
                sel_tag  = bus.req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    // FSM next-state and single-cycle strobes
    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        capture    = 1'b0;
        reissue    = 1'b0;
        wb_fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    grant_fire = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A finish arriving on the last watchdog cycle still wins
                if (bus.fu_finish) begin
                    capture = 1'b1;
                    state_d = S_WB;
                end else if (wdog_q == WDOG_LIMIT) begin
                    reissue = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_WB: begin
                if (bus.wb_ready) begin
                    wb_fire = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted slot's operation and advance the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= IDX_W'(N_REQ - 1);
            op_ctrl_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_tag_q  <= '0;
            op_src_q  <= '0;
        end else if (grant_fire) begin
            last_q    <= grant_idx;
            op_ctrl_q <= sel_ctrl;
            op_a_q    <= sel_a;
            op_b_q    <= sel_b;
            op_tag_q  <= sel_tag;
            op_src_q  <= grant_idx;
        end
    end

    // Watchdog: cleared on every issue, counts (saturating) while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else if (state_q == S_ISSUE) begin
            wdog_q <= '0;
        end else if (state_q == S_WAIT && !bus.fu_finish && wdog_q != WDOG_MAX) begin
            wdog_q <= wdog_q + 5'd1;
        end
    end

    // Latch the FU result with its tag; frozen for the whole WB stay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_tag_q  <= '0;
            wb_src_q  <= '0;
            wb_res_q  <= '0;
            wb_zero_q <= 1'b0;
            wb_ovf_q  <= 1'b0;
        end else if (capture) begin
            wb_tag_q  <= op_tag_q;
            wb_src_q  <= 3'(op_src_q);
            wb_res_q  <= bus.fu_res;
            wb_zero_q <= bus.fu_zero;
            wb_ovf_q  <= bus.fu_overflow;
        end
    end

    // Sticky reissue flag and completed write-back counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (reissue) begin
                err_q <= 1'b1;
            end
            if (wb_fire) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // Grant pulse only in IDLE; FU strobe only in ISSUE, so never back-to-back
    assign bus.req_ready   = grant_fire ? (N_REQ'(1) << grant_idx) : '0;
    assign bus.fu_en       = (state_q == S_ISSUE);
    assign bus.fu_ctrl     = op_ctrl_q;
    assign bus.fu_a        = op_a_q;
    assign bus.fu_b        = op_b_q;

    assign bus.wb_valid    = (state_q == S_WB);
    assign bus.wb_tag      = wb_tag_q;
    assign bus.wb_src      = wb_src_q;
    assign bus.wb_res      = wb_res_q;
    assign bus.wb_zero     = wb_zero_q;
    assign bus.wb_overflow = wb_ovf_q;

    assign err_timeout     = err_q;
    assign op_count        = cnt_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_alu_fu_sched.sv
// Directed bench for alu_fu_sched: single op, round-robin, backpressure,
// overflow, watchdog reissue and asynchronous reset mid-operation.
module tb_alu_fu_sched;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        err_timeout;
    logic [31:0] op_count;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // FU model bookkeeping: the EN whose index equals drop_idx gets no finish
    int unsigned en_count = 0;
    int unsigned drop_idx = 32'hFFFF_FFFF;

    logic [31:0] exp_q[$];

    alu_fu_sched_if #(.N_REQ(4), .TAG_W(3)) bus();

    alu_fu_sched #(.N_REQ(4), .TAG_W(3), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .err_timeout (err_timeout),
        .op_count    (op_count),
        .state_dbg   (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference ALU: returns {overflow, result}
    function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (c)
            C_ADD: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            C_SUB: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            C_AND: r = a & b;
            default: r = a | b;
        endcase
        return {v, r};
    endfunction

    // FU model: answers one cycle after EN unless that EN is marked to drop
    always @(posedge clk) begin
        if (bus.fu_en === 1'b1) begin
            logic [32:0] r;
            r = alu_ref(bus.fu_ctrl, bus.fu_a, bus.fu_b);
            en_count        <= en_count + 1;
            bus.fu_finish   <= (en_count != drop_idx);
            bus.fu_res      <= r[31:0];
            bus.fu_zero     <= (r[31:0] == 32'd0);
            bus.fu_overflow <= r[32];
        end else begin
            bus.fu_finish   <= 1'b0;
        end
    end

    // Global bound on simulation time
    initial begin
        #200000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "simulation time bound exceeded");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp_v);
        end
    endtask

    task automatic set_slot(input int s, input logic [3:0] c, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] t);
        bus.req_ctrl[s*4 +: 4]   = c;
        bus.req_a[s*32 +: 32]    = a;
        bus.req_b[s*32 +: 32]    = b;
        bus.req_tag[s*3 +: 3]    = t;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete operation with wb_ready high: grant T, EN T+1, WB T+3
    task automatic do_op(input int slot, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] t,
                         input logic [31:0] exp_res, input logic exp_z, input logic exp_o,
                         input logic [31:0] exp_cnt);
        @(negedge clk);
        set_slot(slot, c, a, b, t);
        bus.req_valid       = '0;
        bus.req_valid[slot] = 1'b1;
        bus.wb_ready        = 1'b1;
        #1;
        check("op_grant", 32'(bus.req_ready), 32'(1) << slot);
        check("op_grant_en", 32'(bus.fu_en), 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("op_issue_en", 32'(bus.fu_en), 32'd1);
        check("op_issue_a", bus.fu_a, a);
        check("op_issue_b", bus.fu_b, b);
        check("op_issue_ctrl", 32'(bus.fu_ctrl), 32'(c));
        check("op_issue_rdy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("op_wait_en", 32'(bus.fu_en), 32'd0);
        check("op_wait_hold_a", bus.fu_a, a);
        check("op_wait_valid", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        #1;
        check("op_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("op_wb_res", bus.wb_res, exp_res);
        check("op_wb_tag", 32'(bus.wb_tag), 32'(t));
        check("op_wb_src", 32'(bus.wb_src), 32'(slot));
        check("op_wb_zero", 32'(bus.wb_zero), 32'(exp_z));
        check("op_wb_ovf", 32'(bus.wb_overflow), 32'(exp_o));
        @(negedge clk);
        #1;
        check("op_after_valid", 32'(bus.wb_valid), 32'd0);
        check("op_count", op_count, exp_cnt);
    endtask

    initial begin
        logic [3:0]  exp_rdy;
        logic        prev_en;
        logic [31:0] exp_res;
        int          n_en;

        bus.req_valid = '0;
        bus.req_ctrl  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.wb_ready  = 1'b0;
        #2 rst_n = 1'b0;

        // ---------------- reset values
        @(negedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_fu_en", 32'(bus.fu_en), 32'd0);
        check("rst_fu_ctrl", 32'(bus.fu_ctrl), 32'd0);
        check("rst_fu_a", bus.fu_a, 32'd0);
        check("rst_fu_b", bus.fu_b, 32'd0);
        check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("rst_wb_res", bus.wb_res, 32'd0);
        check("rst_wb_tag", 32'(bus.wb_tag), 32'd0);
        check("rst_wb_src", 32'(bus.wb_src), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_op_count", op_count, 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- single request: slot 2, 5 + 7, tag 3
        do_op(2, C_ADD, 32'd5, 32'd7, 3'd3, 32'd12, 1'b0, 1'b0, 32'd1);

        // ---------------- round-robin with all slots valid
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_slot(i, C_ADD, 32'(100 + i), 32'(i), 3'(4 + i));
        end
        bus.wb_ready = 1'b1;
        prev_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) bus.req_valid = 4'hF;
            #1;
            exp_rdy = (c % 4 == 0) ? (4'b0001 << ((c / 4) % 4)) : 4'b0000;
            check("rr_grant", 32'(bus.req_ready), 32'(exp_rdy));
            if (c % 4 == 0) exp_q.push_back(32'(100 + 2 * ((c / 4) % 4)));
            check("rr_en_b2b", 32'(bus.fu_en & prev_en), 32'd0);
            prev_en = bus.fu_en;
            if (c % 4 == 3) begin
                check("rr_wb_valid", 32'(bus.wb_valid), 32'd1);
                check("rr_wb_src", 32'(bus.wb_src), 32'((c / 4) % 4));
                exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("rr_wb_res", bus.wb_res, exp_res);
            end
        end
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        check("rr_op_count", op_count, 32'd5);

        // ---------------- backpressure: 3 - 3 with wb_ready low 10 cycles
        @(negedge clk);
        set_slot(1, C_SUB, 32'd3, 32'd3, 3'd5);
        bus.req_valid = 4'b0010;
        bus.wb_ready  = 1'b0;
        #1;
        check("bp_grant", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #1;
        check("bp_issue_en", 32'(bus.fu_en), 32'd1);
        @(negedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check("bp_wb_valid", 32'(bus.wb_valid), 32'd1);
            check("bp_wb_res", bus.wb_res, 32'd0);
            check("bp_wb_zero", 32'(bus.wb_zero), 32'd1);
            check("bp_no_grant", 32'(bus.req_ready), 32'd0);
            check("bp_no_en", 32'(bus.fu_en), 32'd0);
            check("bp_count_hold", op_count, 32'd5);
        end
        @(negedge clk);
        bus.wb_ready  = 1'b1;
        bus.req_valid = '0;
        #1;
        check("bp_release_valid", 32'(bus.wb_valid), 32'd1);
        check("bp_release_tag", 32'(bus.wb_tag), 32'd5);
        @(negedge clk);
        #1;
        check("bp_op_count", op_count, 32'd6);
        check("bp_after_valid", 32'(bus.wb_valid), 32'd0);

        // ---------------- signed overflow
        do_op(2, C_ADD, 32'h7FFF_FFFF, 32'd1, 3'd1, 32'h8000_0000, 1'b0, 1'b1, 32'd7);

        // ---------------- watchdog reissue: first EN gets no finish
        apply_reset();
        drop_idx = en_count;
        @(negedge clk);
        set_slot(3, C_AND, 32'h0000_F0F0, 32'h0000_0FF0, 3'd6);
        bus.req_valid = 4'b1000;
        bus.wb_ready  = 1'b1;
        #1;
        check("to_grant", 32'(bus.req_ready), 32'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("to_first_en", 32'(bus.fu_en), 32'd1);
        n_en = 1;
        for (int w = 0; w < 9; w++) begin
            @(negedge clk);
            #1;
            check("to_wait_en", 32'(bus.fu_en), 32'd0);
            check("to_err_early", 32'(err_timeout), 32'd0);
            check("to_wait_state", 32'(state_dbg), 32'd2);
        end
        @(negedge clk);
        #1;
        check("to_reissue_en", 32'(bus.fu_en), 32'd1);
        check("to_err_set", 32'(err_timeout), 32'd1);
        check("to_reissue_a", bus.fu_a, 32'h0000_F0F0);
        if (bus.fu_en === 1'b1) n_en++;
        @(negedge clk);
        #1;
        check("to_second_wait_en", 32'(bus.fu_en), 32'd0);
        @(negedge clk);
        #1;
        check("to_wb_valid", 32'(bus.wb_valid), 32'd1);
        check("to_wb_res", bus.wb_res, 32'h0000_00F0);
        check("to_wb_tag", 32'(bus.wb_tag), 32'd6);
        check("to_wb_src", 32'(bus.wb_src), 32'd3);
        @(negedge clk);
        #1;
        check("to_wb_done", 32'(bus.wb_valid), 32'd0);
        check("to_op_count", op_count, 32'd1);
        check("to_err_sticky", 32'(err_timeout), 32'd1);
        check("to_en_pulses", 32'(n_en), 32'd2);
        @(negedge clk);
        #1;
        check("to_single_wb", op_count, 32'd1);

        // ---------------- asynchronous reset during WAIT
        @(negedge clk);
        set_slot(1, C_ADD, 32'd9, 32'd9, 3'd2);
        bus.req_valid = 4'b0010;
        #1;
        check("mr_grant", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("mr_issue_en", 32'(bus.fu_en), 32'd1);
        @(negedge clk);
        #1;
        check("mr_in_wait", 32'(state_dbg), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mr_state", 32'(state_dbg), 32'd0);
        check("mr_fu_en", 32'(bus.fu_en), 32'd0);
        check("mr_fu_a", bus.fu_a, 32'd0);
        check("mr_fu_b", bus.fu_b, 32'd0);
        check("mr_fu_ctrl", 32'(bus.fu_ctrl), 32'd0);
        check("mr_wb_valid", 32'(bus.wb_valid), 32'd0);
        check("mr_wb_res", bus.wb_res, 32'd0);
        check("mr_wb_tag", 32'(bus.wb_tag), 32'd0);
        check("mr_wb_src", 32'(bus.wb_src), 32'd0);
        check("mr_err", 32'(err_timeout), 32'd0);
        check("mr_op_count", op_count, 32'd0);
        check("mr_req_ready", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("mr_hold_no_wb", 32'(bus.wb_valid), 32'd0);
        end
        rst_n = 1'b1;
        do_op(0, C_ADD, 32'd1, 32'd2, 3'd0, 32'd3, 1'b0, 1'b0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
